// File: rtl/gate_truth_sequencer.sv
// rtl/gate_truth_sequencer.sv - walks a 2-input gate through its truth table and scores the output
module gate_truth_sequencer #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
  // With zero settle time each vector goes straight to its one-cycle check.
  localparam state_t LP_FIRST = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;
  logic [3:0] r_mask;

  logic       w_start;
  logic       w_mismatch;
  logic [2:0] w_err_inc;
  logic [3:0] w_mask_inc;

  // Start only counts when no run is in flight; scoring of the current vector.
  always_comb begin
    w_start    = start && (r_state == S_IDLE || r_state == S_DONE);
    // Case-inequality so an X/Z on y is scored as a failure in simulation.
    w_mismatch = (y !== TRUTH_TABLE[r_vec]);
    w_err_inc  = r_err + {2'b00, w_mismatch};
    w_mask_inc = w_mismatch ? (r_mask | (4'b0001 << r_vec)) : r_mask;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_next = LP_FIRST;
        end
      end
      S_SETTLE: begin
        if (r_cnt <= 4'd1) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_next = (r_vec == 2'd3) ? S_DONE : LP_FIRST;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered vector, settle counter and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec  <= 2'd0;
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= 3'd0;
      r_mask <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_vec  <= 2'd0;
            r_cnt  <= LP_SETTLE;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 3'd0;
            r_mask <= 4'd0;
          end
        end
        S_SETTLE: begin
          r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        end
        S_CHECK: begin
          r_err  <= w_err_inc;
          r_mask <= w_mask_inc;
          if (r_vec == 2'd3) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_err_inc == 3'd0);
          end else begin
            r_vec <= r_vec + 2'd1;
            r_cnt <= LP_SETTLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    a         = r_vec[1];
    b         = r_vec[0];
    busy      = r_busy;
    done      = r_done;
    pass      = r_pass;
    err_count = r_err;
    fail_mask = r_mask;
  end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb/tb_gate_truth_sequencer.sv - directed bench for gate_truth_sequencer
module tb_gate_truth_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic [1:0] mode;

  logic       start6;
  logic       y6;
  logic       a6, b6, busy6, done6, pass6;
  logic [2:0] err6;
  logic [3:0] mask6;
  logic       mode6;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Gate models driven by the sequencer outputs: 0 NAND, 1 AND, 2 stuck-at-1.
  always_comb begin
    case (mode)
      2'd0:    y = ~(a & b);
      2'd1:    y = a & b;
      default: y = 1'b1;
    endcase
    y6 = mode6 ? (a6 | b6) : (a6 ^ b6);
  end

  gate_truth_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask)
  );

  gate_truth_sequencer #(.TRUTH_TABLE(4'b0110), .SETTLE_CYCLES(0)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .y(y6),
    .a(a6), .b(b6), .busy(busy6), .done(done6), .pass(pass6),
    .err_count(err6), .fail_mask(mask6)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full default-parameter run from a one-cycle start pulse.
  task automatic run_default(input logic [2:0] e_err, input logic [3:0] e_mask, input logic e_pass);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ab", {a, b}, 8'd0);
    chk("start_busy", busy, 8'd1);
    chk("start_done", done, 8'd0);
    chk("start_err_clr", err_count, 8'd0);
    chk("start_mask_clr", fail_mask, 8'd0);
    for (int e = 1; e < 12; e++) begin
      step();
      chk("hold_ab", {a, b}, 8'(e / 3));
      chk("hold_busy", {busy, done}, 8'b10);
    end
    step();
    chk("end_done", done, 8'd1);
    chk("end_busy", busy, 8'd0);
    chk("end_ab", {a, b}, 8'd3);
    chk("end_err", err_count, 8'(e_err));
    chk("end_mask", fail_mask, 8'(e_mask));
    chk("end_pass", pass, 8'(e_pass));
  endtask

  // Run of the zero-settle XOR-table instance.
  task automatic run_six(input logic [2:0] e_err, input logic [3:0] e_mask, input logic e_pass);
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    chk("s6_start_ab", {a6, b6}, 8'd0);
    chk("s6_start_busy", busy6, 8'd1);
    for (int e = 1; e < 4; e++) begin
      step();
      chk("s6_hold_ab", {a6, b6}, 8'(e));
      chk("s6_hold_done", done6, 8'd0);
    end
    step();
    chk("s6_done", {busy6, done6}, 8'b01);
    chk("s6_err", err6, 8'(e_err));
    chk("s6_mask", mask6, 8'(e_mask));
    chk("s6_pass", pass6, 8'(e_pass));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start6 = 1'b0;
    mode   = 2'd0;
    mode6  = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_outs", {a, b, busy, done, pass}, 8'd0);
    chk("rst_err", err_count, 8'd0);
    chk("rst_mask", fail_mask, 8'd0);
    chk("rst_outs6", {a6, b6, busy6, done6, pass6}, 8'd0);
    step();
    chk("idle_stays", {busy, done}, 8'd0);

    // Ideal NAND
    mode = 2'd0;
    run_default(3'd0, 4'b0000, 1'b1);
    step();
    chk("done_holds", {done, a, b}, 8'b111);

    // AND gate: every vector wrong
    mode = 2'd1;
    run_default(3'd4, 4'b1111, 1'b0);

    // Stuck-at-1: only vector 11 wrong; also checks clear on restart from DONE
    mode = 2'd2;
    run_default(3'd1, 4'b1000, 1'b0);

    // Start held high for the whole run must not restart it
    mode  = 2'd0;
    start = 1'b1;
    step();
    chk("held_start_ab", {a, b}, 8'd0);
    for (int e = 1; e < 12; e++) begin
      step();
      chk("held_ab", {a, b}, 8'(e / 3));
      chk("held_busy", busy, 8'd1);
    end
    step();
    start = 1'b0;
    chk("held_done", {done, pass}, 8'b11);
    chk("held_err", err_count, 8'd0);
    step();
    step();
    chk("held_done_stays", {done, busy, a, b}, 8'b1011);

    // Restart from DONE, then a reset in the middle of vector 10
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_state", {done, busy, a, b}, 8'b0100);
    for (int e = 1; e < 7; e++) step();
    chk("mid_vec10", {a, b}, 8'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_outs", {a, b, busy, done, pass}, 8'd0);
    chk("midrst_err", err_count, 8'd0);
    chk("midrst_mask", fail_mask, 8'd0);
    step();
    step();
    chk("midrst_idle", {busy, done, a, b}, 8'd0);
    run_default(3'd0, 4'b0000, 1'b1);

    // XOR table, no settle time
    mode6 = 1'b0;
    run_six(3'd0, 4'b0000, 1'b1);
    mode6 = 1'b1;
    run_six(3'd1, 4'b1000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_truth_sequencer.md
Name: gate_truth_sequencer

Overview:
Self-checking stimulus sequencer that sits directly upstream of a 2-input gate (default: the NAND gate) and drives its inputs a and b. It walks all four input combinations, waits a programmable settle time per vector, and samples the gate output y. It compares y against a parameterised truth table and reports error count, per-vector fail mask, pass and done.

Parameters:
TRUTH_TABLE, 4'b0111, expected y per vector; bit index = {a,b}; default is NAND.
SETTLE_CYCLES, 2, cycles each vector is held before y is sampled; legal 0..15.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a run; sampled only in IDLE or DONE
y  input  1  output of gate under test
a  output  1  gate input a (registered)
b  output  1  gate input b (registered)
busy  output  1  high while a run is in progress (SETTLE/CHECK)
done  output  1  high in DONE until next start or rst
pass  output  1  high in DONE when err_count==0
err_count  output  3  number of mismatched vectors (0..4)
fail_mask  output  4  bit i set if vector i={a,b} mismatched

Behaviour:
- Reset: rst high at an edge -> state IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, vector index=0, settle counter=0. rst overrides start and any in-flight run.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1 at edge:
  - vec=0, {a,b}=00; err_count, fail_mask, pass, done cleared; busy=1.
  - Next state SETTLE with counter=SETTLE_CYCLES, or CHECK directly if SETTLE_CYCLES==0.
- SETTLE: counter decrements each edge; on the edge where counter reaches 0 -> CHECK. The vector is held SETTLE_CYCLES cycles in SETTLE.
- CHECK: one cycle; y sampled at the edge leaving CHECK.
  - Mismatch when y !== TRUTH_TABLE[{a,b}]. X/Z counts as a mismatch.
  - On mismatch: err_count+1, fail_mask[vec]=1.
  - If vec<3: vec+1, {a,b}=vec+1 (order 00,01,10,11), go to SETTLE (or CHECK if SETTLE_CYCLES==0).
  - If vec==3: go to DONE with busy=0, done=1, and pass computed from the final count, including the current comparison.
- Per-vector hold: SETTLE_CYCLES+1 cycles. done rises 4*(SETTLE_CYCLES+1) edges after the start edge (12 at default).
- DONE: a,b hold 11; results stable.
  - start=1 -> identical to start from IDLE (clears results, restarts at 00); done drops at that edge.
  - start=0 -> remain in DONE.
- start while busy: ignored, no restart, no effect on results.
- err_count saturation is not needed (max 4 fits 3 bits).
- Outputs are all registered; no combinational path from y or start to any output.

Test Plan:
1. Defaults, ideal NAND DUT, 1-cycle start pulse -> a,b = 00,01,10,11, each held 3 cycles; busy high 12 cycles; done=1 at edge 12 after start; err_count=0, fail_mask=0000, pass=1.
2. Defaults, AND gate as DUT (y=a&b) -> all four vectors mismatch; err_count=4, fail_mask=1111, pass=0, done=1.
3. Defaults, y stuck at 1 -> only vector 11 fails; err_count=1, fail_mask=1000, pass=0.
4. Hold start high for the whole run; also pulse start at cycle 5 -> no restart, done at edge 12. Then pulse start in DONE -> next edge done=0, err_count=0, a,b=00, busy=1; run completes again.
5. Assert rst for 1 cycle while vector 10 is driven -> next edge all outputs 0, state IDLE. A later start produces a normal 12-cycle run with pass=1.
6. TRUTH_TABLE=4'b0110, SETTLE_CYCLES=0, XOR DUT -> each vector held 1 cycle; done 4 edges after start; pass=1. Same with an OR DUT -> err_count=1, fail_mask=1000.
